wave_capture_ctrl: RTL and testbench

WAVE_CAPTURE_CTRL -- requirements
Module: wave_capture_ctrl

---
 rtl/wave_capture_ctrl_if.sv | 16 +
 rtl/wave_capture_ctrl.sv | 148 ++++++++++++++
 tb/tb_wave_capture_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/wave_capture_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wave_capture_ctrl_if : capture-bank write port of the waveform RAM   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface wave_capture_ctrl_if;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_bank;
  logic       disp_bank;

  modport master (output wr_en, wr_addr, wr_data, wr_bank, disp_bank);
  modport slave  (input  wr_en, wr_addr, wr_data, wr_bank, disp_bank);
endinterface
`default_nettype wire

// File: rtl/wave_capture_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wave_capture_ctrl : triggered, double-buffered waveform record ctrl  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wave_capture_ctrl #(
  parameter int DEPTH   = 800,
  parameter int TIMEOUT = 2000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          key_out,
  input  logic [7:0]          wave,
  input  logic [7:0]          trig_level,
  input  logic [3:0]          decim,
  input  logic                auto_en,
  input  logic                frame_start,
  wave_capture_ctrl_if.master wr,
  output logic                running,
  output logic                busy,
  output logic                forced
);
  localparam int              TO_W      = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [9:0]      LAST_ADDR = 10'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t          state_q;
  logic            running_q, busy_q, forced_q;
  logic            wr_en_q, wr_bank_q, prev_vld_q;
  logic [9:0]      wr_addr_q, idx_q;
  logic [7:0]      wr_data_q, prev_q;
  logic [3:0]      decim_q, div_q;
  logic [TO_W-1:0] to_q;

  logic running_d, arm, strobe, crossing, timed_out;

  assign running_d = running_q ^ key_out[0];
  assign arm       = key_out[1] & ~key_out[0];
  assign strobe    = (div_q == decim_q);
  // prev is only meaningful once a strobe has been seen in this arming,
  // otherwise a stale value from the last record could fake a crossing
  assign crossing  = strobe && prev_vld_q && (prev_q < trig_level) && (wave >= trig_level);
  assign timed_out = auto_en && (to_q == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      running_q  <= 1'b0;
      busy_q     <= 1'b0;
      forced_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_bank_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      idx_q      <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      decim_q    <= '0;
      div_q      <= '0;
      to_q       <= '0;
    end else begin
      running_q <= running_d;
      wr_en_q   <= 1'b0;

      if (state_q == WAIT_TRIG || state_q == CAPTURE) begin
        div_q <= strobe ? 4'd0 : div_q + 4'd1;
        if (strobe) begin
          prev_q     <= wave;
          prev_vld_q <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (running_d || arm) begin
            state_q    <= WAIT_TRIG;
            busy_q     <= 1'b1;
            div_q      <= '0;
            decim_q    <= decim;
            to_q       <= '0;
            prev_vld_q <= 1'b0;
          end
        end

        WAIT_TRIG: begin
          if (to_q != TO_LAST) to_q <= to_q + TO_W'(1);
          if (running_q && !running_d) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (crossing || timed_out) begin
            state_q   <= (LAST_ADDR == 10'd0) ? DONE : CAPTURE;
            forced_q  <= ~crossing;
            wr_en_q   <= 1'b1;
            wr_addr_q <= '0;
            wr_data_q <= wave;
            idx_q     <= 10'd1;
          end
        end

        CAPTURE: begin
          if (strobe) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= idx_q;
            wr_data_q <= wave;
            idx_q     <= idx_q + 10'd1;
            if (idx_q == LAST_ADDR) state_q <= DONE;
          end
        end

        DONE: begin
          // swapping only at frame start keeps a displayed frame whole
          if (frame_start) begin
            wr_bank_q <= ~wr_bank_q;
            if (running_d) begin
              state_q    <= WAIT_TRIG;
              div_q      <= '0;
              decim_q    <= decim;
              to_q       <= '0;
              prev_vld_q <= 1'b0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr.wr_en     = wr_en_q;
  assign wr.wr_addr   = wr_addr_q;
  assign wr.wr_data   = wr_data_q;
  assign wr.wr_bank   = wr_bank_q;
  assign wr.disp_bank = ~wr_bank_q;
  assign running      = running_q;
  assign busy         = busy_q;
  assign forced       = forced_q;
endmodule
`default_nettype wire

// File: tb/tb_wave_capture_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_wave_capture_ctrl : directed bench for wave_capture_ctrl          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_wave_capture_ctrl;
  localparam int DEPTH   = 800;
  localparam int TIMEOUT = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key_out;
  logic [7:0] wave, trig_level, hold_val;
  logic [3:0] decim;
  logic       auto_en, frame_start, ramp_en;
  logic       running, busy, forced;

  int n_checks, n_fail;
  int lat, n, fd, la, ld, g, nw;

  wave_capture_ctrl_if wr_if ();

  wave_capture_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_out     (key_out),
    .wave        (wave),
    .trig_level  (trig_level),
    .decim       (decim),
    .auto_en     (auto_en),
    .frame_start (frame_start),
    .wr          (wr_if.master),
    .running     (running),
    .busy        (busy),
    .forced      (forced)
  );

  always #5 clk = ~clk;

  // DDS stand-in: free-running ramp or a held level
  always @(posedge clk) begin
    if (rst) wave <= 8'd0;
    else     wave <= ramp_en ? wave + 8'd1 : hold_val;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_key(input logic [1:0] k);
    key_out = k;
    tick();
    key_out = 2'b00;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // single-shot arm on the edge that samples wave == target
  task automatic arm_at(input logic [7:0] target);
    int guard = 0;
    while (wave !== target && guard < 600) begin
      tick();
      guard++;
    end
    check("arm_phase", 32'(guard < 600), 1);
    pulse_key(2'b10);
  endtask

  // waits for the first write, then checks a whole record against
  // data(k) = d0 + k*step and a fixed write spacing of gap clocks
  task automatic capture_record(input int gap, input int d0, input int step, input int stop_at,
                                input string tag, output int o_lat, output int o_n,
                                output int o_fd, output int o_la, output int o_ld);
    int since = 0, bad_gap = 0, bad_addr = 0, bad_data = 0, exp_d;
    o_lat = 0; o_n = 0; o_fd = -1; o_la = -1; o_ld = -1;
    while (wr_if.wr_en !== 1'b1 && o_lat < 3000) begin
      tick();
      o_lat++;
    end
    check({tag, "_started"}, 32'(wr_if.wr_en), 1);
    for (int c = 0; c < DEPTH * gap + 40; c++) begin
      if (c > 0) tick();
      key_out = 2'b00;
      if (wr_if.wr_en === 1'b1) begin
        if (o_n > 0 && since != gap) bad_gap++;
        if (wr_if.wr_addr !== 10'(o_n)) bad_addr++;
        exp_d = (d0 + o_n * step) & 255;
        if (wr_if.wr_data !== 8'(exp_d)) bad_data++;
        if (o_n == 0) o_fd = int'(wr_if.wr_data);
        o_la = int'(wr_if.wr_addr);
        o_ld = int'(wr_if.wr_data);
        o_n++;
        since = 0;
        if (o_n == stop_at) key_out = 2'b01;
      end
      since++;
    end
    check({tag, "_count"}, 32'(o_n), DEPTH);
    check({tag, "_gap_errs"}, 32'(bad_gap), 0);
    check({tag, "_addr_errs"}, 32'(bad_addr), 0);
    check({tag, "_data_errs"}, 32'(bad_data), 0);
    check({tag, "_busy_done"}, 32'(busy), 1);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; key_out = 2'b00; trig_level = 8'd128; decim = 4'd0;
    auto_en = 1'b0; frame_start = 1'b0; ramp_en = 1'b1; hold_val = 8'd0;
    repeat (3) tick();
    check("rst_wr_en",     32'(wr_if.wr_en), 0);
    check("rst_wr_addr",   32'(wr_if.wr_addr), 0);
    check("rst_wr_data",   32'(wr_if.wr_data), 0);
    check("rst_wr_bank",   32'(wr_if.wr_bank), 0);
    check("rst_disp_bank", 32'(wr_if.disp_bank), 1);
    check("rst_running",   32'(running), 0);
    check("rst_busy",      32'(busy), 0);
    check("rst_forced",    32'(forced), 0);
    rst = 1'b0;
    tick();

    // frame_start outside DONE has no effect
    pulse_frame();
    tick();
    check("fs_idle_bank", 32'(wr_if.wr_bank), 0);

    // reset in the middle of a record
    arm_at(8'd0);
    g = 0;
    while (!(wr_if.wr_en === 1'b1 && wr_if.wr_addr == 10'd400) && g < 2000) begin
      tick();
      g++;
    end
    check("mid_addr_reached", 32'(wr_if.wr_addr), 400);
    rst = 1'b1;
    tick();
    check("mid_rst_wr_en",   32'(wr_if.wr_en), 0);
    check("mid_rst_wr_addr", 32'(wr_if.wr_addr), 0);
    check("mid_rst_busy",    32'(busy), 0);
    check("mid_rst_bank",    32'(wr_if.wr_bank), 0);
    rst = 1'b0;
    tick();

    // ramp, decim 0: trigger at 128, last sample (128+799)%256 = 159
    arm_at(8'd0);
    capture_record(1, 128, 1, -1, "dec0", lat, n, fd, la, ld);
    check("dec0_latency", 32'(lat), 128);
    check("dec0_first",   32'(fd), 128);
    check("dec0_last_a",  32'(la), 799);
    check("dec0_last_d",  32'(ld), 159);
    check("dec0_forced",  32'(forced), 0);

    // record held in DONE until a frame boundary
    nw = 0;
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (wr_if.wr_en === 1'b1) nw++;
    end
    check("hold_writes", 32'(nw), 0);
    check("hold_bank",   32'(wr_if.wr_bank), 0);
    pulse_frame();
    check("swap1_bank", 32'(wr_if.wr_bank), 1);
    check("swap1_disp", 32'(wr_if.disp_bank), 0);
    check("swap1_busy", 32'(busy), 0);

    // decim 3: strobes on wave 4,8,..; last = (128+799*4)%256 = 252
    decim = 4'd3;
    arm_at(8'd0);
    decim = 4'd0;
    capture_record(4, 128, 4, -1, "dec3", lat, n, fd, la, ld);
    check("dec3_latency", 32'(lat), 128);
    check("dec3_first",   32'(fd), 128);
    check("dec3_last_d",  32'(ld), 252);
    pulse_frame();
    check("swap2_bank", 32'(wr_if.wr_bank), 0);

    // flat wave never crosses: auto trigger after TIMEOUT clocks
    ramp_en = 1'b0; hold_val = 8'd10; auto_en = 1'b1;
    tick(); tick();
    arm_at(8'd10);
    capture_record(1, 10, 0, -1, "auto", lat, n, fd, la, ld);
    check("auto_latency", 32'(lat), 1000);
    check("auto_forced",  32'(forced), 1);
    check("auto_first",   32'(fd), 10);
    auto_en = 1'b0;
    pulse_frame();
    check("swap3_bank", 32'(wr_if.wr_bank), 1);

    // run mode, stopped mid-record: record completes, then IDLE
    ramp_en = 1'b1;
    pulse_key(2'b01);
    check("run_on", 32'(running), 1);
    capture_record(1, 128, 1, 100, "runstop", lat, n, fd, la, ld);
    check("runstop_running", 32'(running), 0);
    check("runstop_first",   32'(fd), 128);
    pulse_frame();
    check("swap4_bank", 32'(wr_if.wr_bank), 0);
    check("swap4_busy", 32'(busy), 0);
    nw = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (wr_if.wr_en === 1'b1 || busy === 1'b1) nw++;
    end
    check("idle_after_stop", 32'(nw), 0);

    // stop while waiting for a trigger returns to IDLE at once
    ramp_en = 1'b0; hold_val = 8'd10;
    tick(); tick();
    pulse_key(2'b01);
    tick();
    check("wait_busy", 32'(busy), 1);
    pulse_key(2'b01);
    check("wait_stop_busy",    32'(busy), 0);
    check("wait_stop_running", 32'(running), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
